// File: rtl/fetch_queue.sv
// fetch_queue: byte-queue instruction fetcher and Y86-style decoder
//   clk, rst_n                  clock, async active-low reset
//   redirect_valid/redirect_pc  load new fetch and decode PC, flush queue
//   mem_req/mem_addr            one-cycle read request of FETCH_BYTES bytes
//   mem_rvalid/mem_rdata        read response, byte k = mem_addr+k
//   out_valid/out_ready         decoded-instruction handshake
//   out_icode..out_pc           decoded fields of the head instruction
//   out_invalid/out_adr_err     bad icode / instruction runs past memory end
//   halted                      stopped until the next redirect
module fetch_queue #(
  parameter int FETCH_BYTES = 2,
  parameter int QDEPTH      = 16,
  parameter int IMEM_BYTES  = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     mem_req,
  output logic [63:0]              mem_addr,
  input  logic                     mem_rvalid,
  input  logic [8*FETCH_BYTES-1:0] mem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [63:0]              out_valC,
  output logic [63:0]              out_valP,
  output logic [63:0]              out_pc,
  output logic                     out_invalid,
  output logic                     out_adr_err,
  output logic                     halted
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_d;
  logic [63:0] fetch_pc, dec_pc, valc;
  logic [PW-1:0] head;
  logic [CW-1:0] count, n_pop;
  logic outst, drop, has_reg, invalid, adr_err, valid, fire, enq, req;
  logic [7:0] qbuf [QDEPTH];
  logic [7:0] b [10];
  logic [3:0] icode, len;
  always_comb begin
    for (int k = 0; k < 10; k++) b[k] = qbuf[head + PW'(k)];
  end
  assign icode   = b[0][7:4];
  assign len     = icode inside {4'h3, 4'h4, 4'h5} ? 4'd10 :
                   icode inside {4'h7, 4'h8} ? 4'd9 :
                   icode inside {4'h2, 4'h6, 4'hA, 4'hB} ? 4'd2 : 4'd1;
  assign has_reg = len == 4'd2 || len == 4'd10;
  assign invalid = icode >= 4'hC;
  assign valc    = len == 4'd10 ? {b[2], b[3], b[4], b[5], b[6], b[7], b[8], b[9]} :
                   len == 4'd9  ? {b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]} : '0;
  // 65-bit sum so a PC near the top of the address space still faults
  assign adr_err = {1'b0, dec_pc} + 65'(len) > 65'(IMEM_BYTES);
  // a faulting instruction is presented as soon as its first byte exists
  assign valid   = state == RUN && count != '0 && (count >= CW'(len) || adr_err);
  assign fire    = valid && out_ready;
  // drop marks a response belonging to a request made before a redirect
  assign enq     = mem_rvalid && outst && !drop;
  assign req     = !outst && state == RUN && fetch_pc < 64'(IMEM_BYTES) &&
                   CW'(QDEPTH) - count >= CW'(FETCH_BYTES) && !redirect_valid;
  // a faulting instruction may be shorter than its length; never pop past count
  assign n_pop   = !fire ? '0 : count < CW'(len) ? count : CW'(len);
  always_comb begin
    state_d = redirect_valid ? RUN : fire && (icode == 4'h0 || invalid || adr_err) ? HALT : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      fetch_pc <= '0;
      dec_pc   <= '0;
      head     <= '0;
      count    <= '0;
      outst    <= 1'b0;
      drop     <= 1'b0;
    end else begin
      state <= state_d;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        dec_pc   <= redirect_pc;
        count    <= '0;
        outst    <= outst && !mem_rvalid;
        drop     <= outst && !mem_rvalid;
      end else begin
        if (req) fetch_pc <= fetch_pc + 64'(FETCH_BYTES);
        if (fire) begin
          dec_pc <= dec_pc + 64'(len);
          head   <= head + n_pop[PW-1:0];
        end
        count <= count + (enq ? CW'(FETCH_BYTES) : '0) - n_pop;
        outst <= req || (outst && !mem_rvalid);
        drop  <= drop && !mem_rvalid;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (enq && !redirect_valid)
      for (int k = 0; k < FETCH_BYTES; k++) qbuf[head + count[PW-1:0] + PW'(k)] <= mem_rdata[8*k +: 8];
  end
  // outputs are gated so that reset forces every one of them to zero
  assign mem_req     = rst_n && req;
  assign mem_addr    = rst_n ? fetch_pc : '0;
  assign out_valid   = rst_n && valid;
  assign out_icode   = rst_n ? icode : '0;
  assign out_ifun    = rst_n ? b[0][3:0] : '0;
  assign out_rA      = !rst_n ? '0 : has_reg ? b[1][7:4] : 4'hF;
  assign out_rB      = !rst_n ? '0 : has_reg ? b[1][3:0] : 4'hF;
  assign out_valC    = rst_n ? valc : '0;
  assign out_valP    = rst_n ? dec_pc + 64'(len) : '0;
  assign out_pc      = rst_n ? dec_pc : '0;
  assign out_invalid = rst_n && invalid;
  assign out_adr_err = rst_n && adr_err;
  assign halted      = rst_n && state == HALT;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random-latency memory plus instruction-stream reference model
module tb_fetch_queue;
  localparam int FB = 2;
  localparam int QD = 16;
  localparam int IM = 1024;
  logic clk = 0, rst_n = 0, redirect_valid = 0, mem_rvalid = 0, out_ready = 0;
  logic [63:0] redirect_pc = '0;
  logic [8*FB-1:0] mem_rdata = '0;
  logic mem_req, out_valid, out_invalid, out_adr_err, halted;
  logic [63:0] mem_addr, out_valC, out_valP, out_pc;
  logic [3:0] out_icode, out_ifun, out_rA, out_rB;
  fetch_queue #(.FETCH_BYTES(FB), .QDEPTH(QD), .IMEM_BYTES(IM)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_rA(out_rA), .out_rB(out_rB), .out_valC(out_valC), .out_valP(out_valP), .out_pc(out_pc),
    .out_invalid(out_invalid), .out_adr_err(out_adr_err), .halted(halted));
  always #5 clk = ~clk;
  logic [7:0] mem [IM];
  int checks = 0, failures = 0, dut_acc = 0;
  logic [63:0] dpc, faddr, resp_addr;
  int cnt, resp_lat;
  bit m_out, stale, m_halt, resp_pend, fast;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] mb(input logic [63:0] a);
    return a < 64'(IM) ? mem[a[9:0]] : 8'h00;
  endfunction
  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h7, 4'h8:             return 9;
      4'h3, 4'h4, 4'h5:       return 10;
      default:                return 1;
    endcase
  endfunction
  task automatic model_init();
    dpc = 0; faddr = 0; cnt = 0; m_out = 0; stale = 0; m_halt = 0; resp_pend = 0;
  endtask
  task automatic step(input bit rd, input logic [63:0] rpc, input bit rdy);
    logic [7:0] b0, b1;
    logic [3:0] ic;
    logic [63:0] vc;
    int L, n;
    bit ae, ev, er;
    redirect_valid = rd; redirect_pc = rpc; out_ready = rdy; mem_rvalid = 0;
    if (resp_pend) begin
      resp_lat--;
      if (resp_lat == 0) begin
        mem_rvalid = 1; resp_pend = 0;
        for (int k = 0; k < FB; k++) mem_rdata[8*k +: 8] = mb(resp_addr + 64'(k));
      end
    end else if ($urandom_range(0, 15) == 0) begin
      mem_rvalid = 1;
      for (int k = 0; k < FB; k++) mem_rdata[8*k +: 8] = 8'($urandom);
    end
    #1;
    b0 = mb(dpc); b1 = mb(dpc + 1); ic = b0[7:4]; L = ilen(ic);
    ae = dpc + 64'(L) > 64'(IM);
    ev = !m_halt && cnt > 0 && (cnt >= L || ae);
    er = !m_out && !m_halt && faddr < 64'(IM) && QD - cnt >= FB && !rd;
    chk("mem_req", mem_req, er);
    if (er) chk("mem_addr", mem_addr, faddr);
    chk("out_valid", out_valid, ev);
    chk("halted", halted, m_halt);
    if (ev) begin
      vc = 0;
      if (L == 10) for (int k = 2; k < 10; k++) vc = {vc[55:0], mb(dpc + 64'(k))};
      else if (L == 9) for (int k = 1; k < 9; k++) vc = {vc[55:0], mb(dpc + 64'(k))};
      chk("icode", out_icode, ic);
      chk("ifun", out_ifun, b0[3:0]);
      chk("pc", out_pc, dpc);
      chk("valP", out_valP, dpc + 64'(L));
      chk("invalid", out_invalid, ic >= 4'hC);
      chk("adr_err", out_adr_err, ae);
      if (!ae) begin
        chk("rA", out_rA, (L == 2 || L == 10) ? b1[7:4] : 4'hF);
        chk("rB", out_rB, (L == 2 || L == 10) ? b1[3:0] : 4'hF);
        chk("valC", out_valC, vc);
      end
    end
    if (out_valid && rdy && !rd) dut_acc++;
    if (rd) begin
      if (m_out && mem_rvalid) begin m_out = 0; stale = 0; end
      else if (m_out) stale = 1;
      cnt = 0; dpc = rpc; faddr = rpc; m_halt = 0;
    end else begin
      n = 0;
      if (ev && rdy) begin
        n = cnt < L ? cnt : L;
        dpc = dpc + 64'(L);
        if (ic == 4'h0 || ic >= 4'hC || ae) m_halt = 1;
      end
      if (mem_rvalid && m_out) begin
        if (!stale) cnt += FB;
        m_out = 0; stale = 0;
      end
      cnt -= n;
      if (er) begin
        m_out = 1; resp_pend = 1; resp_addr = faddr;
        resp_lat = fast ? 1 : $urandom_range(1, 3);
        faddr = faddr + 64'(FB);
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    #2 rst_n = 0;
    redirect_valid = 0; mem_rvalid = 0; out_ready = 0;
    #1;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_rA", out_rA, 0);
    chk("rst_valP", out_valP, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_init();
  endtask
  task automatic run_until_halt(input int maxc, input bit rnd);
    int c;
    c = 0;
    while (!m_halt && c < maxc) begin
      step(0, 0, rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      c++;
    end
    chk("halt_reached", halted, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end
  initial begin
    int a, c;
    logic [3:0] ic;
    logic [7:0] p1 [6];
    logic [7:0] p2 [11];
    p1 = '{8'h60, 8'h03, 8'h20, 8'h03, 8'h10, 8'h00};
    p2 = '{8'h30, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
    for (int i = 0; i < IM; i++) mem[i] = 8'h00;
    for (int i = 0; i < 6; i++) mem[i] = p1[i];
    for (int i = 0; i < 11; i++) mem[8'h40 + i] = p2[i];
    mem[8'h60] = 8'hE0;
    mem[1020] = 8'h30; mem[1021] = 8'hF3; mem[1022] = 8'h00; mem[1023] = 8'h00;
    a = 'h100;
    while (a < 'h3E0) begin
      ic = 4'($urandom_range(1, 11));
      mem[a] = {ic, 4'($urandom)};
      for (int k = 1; k < ilen(ic); k++) mem[a + k] = 8'($urandom);
      a += ilen(ic);
    end
    mem[a] = 8'h00;
    fast = 0;
    model_init();
    @(negedge clk);
    do_reset();
    dut_acc = 0;
    run_until_halt(200, 0);
    chk("seq1_count", dut_acc, 4);
    repeat (3) step(0, 0, 1);
    step(1, 64'h100, 1);
    c = 0;
    while (!m_out && c < 10) begin step(0, 0, 1); c++; end
    step(1, 64'h40, 1);
    dut_acc = 0;
    run_until_halt(200, 0);
    chk("seq40_count", dut_acc, 2);
    step(1, 64'h60, 1);
    dut_acc = 0;
    run_until_halt(200, 0);
    chk("invalid_count", dut_acc, 1);
    step(1, 64'h100, 1);
    run_until_halt(6000, 1);
    fast = 1;
    step(1, 64'h100, 0);
    repeat (20) step(0, 0, 0);
    chk("sat_req", mem_req, 0);
    chk("sat_valid", out_valid, 1);
    fast = 0;
    run_until_halt(6000, 1);
    step(1, 64'h100, 1);
    repeat (5) step(0, 0, 1);
    do_reset();
    dut_acc = 0;
    run_until_halt(200, 0);
    chk("seq1_again", dut_acc, 4);
    step(1, 64'd1020, 1);
    dut_acc = 0;
    run_until_halt(200, 0);
    chk("adr_err_count", dut_acc, 1);
    repeat (3) step(0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_BYTES, default 2, meaning bytes returned per memory read (1, 2, 4 or 8).
REQ-002 SHALL have parameter QDEPTH, default 16, meaning byte-queue depth (power of two, >= 10+FETCH_BYTES).
REQ-003 SHALL have parameter IMEM_BYTES, default 1024, meaning instruction-memory size in bytes (multiple of FETCH_BYTES).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous and active-low.
REQ-006 SHALL have port redirect_valid / redirect_pc, input, 1 / 64, meaning load a new fetch PC.
REQ-007 SHALL have port mem_req / mem_addr, output, 1 / 64, meaning read request and its byte address.
REQ-008 SHALL have port mem_rvalid / mem_rdata, input, 1 / 8*FETCH_BYTES, meaning read response; byte k is at mem_rdata[8k+7:8k] and holds address mem_addr+k.
REQ-009 SHALL have port out_valid / out_ready, output / input, 1 / 1, meaning decoded-instruction handshake.
REQ-010 SHALL have ports out_icode, out_ifun, out_rA, out_rB, output, 4 each, meaning instruction fields.
REQ-011 SHALL have ports out_valC / out_valP / out_pc, output, 64 each, meaning constant, next PC and instruction PC.
REQ-012 SHALL have ports out_invalid / out_adr_err / halted, output, 1 each, meaning bad icode, address fault, and stopped.

Function
REQ-013 SHALL keep fetch_pc (next request address), dec_pc (head-instruction PC) and a circular byte queue with count 0..QDEPTH.
REQ-014 SHALL assert mem_req with mem_addr=fetch_pc for exactly one cycle only when all hold: no request outstanding, not halted, fetch_pc < IMEM_BYTES, and QDEPTH-count >= FETCH_BYTES; fetch_pc then advances by FETCH_BYTES.
REQ-015 SHALL allow at most one outstanding request; on mem_rvalid, all FETCH_BYTES bytes SHALL be enqueued in address order.
REQ-016 SHALL decode head byte: icode = bits 7:4, ifun = bits 3:0; second byte gives rA = bits 7:4, rB = bits 3:0.
REQ-017 SHALL use length 1 for icode 0, 1, 9; 2 for icode 2, 6, A, B; 9 for icode 7, 8; 10 for icode 3, 4, 5; 1 with out_invalid=1 for icode C-F.
REQ-018 SHALL take valC from bytes dec_pc+2..dec_pc+9 for icode 3/4/5 and dec_pc+1..dec_pc+8 for icode 7/8, with the lowest-addressed byte most significant; valC SHALL be 0 otherwise.
REQ-019 SHALL drive rA=rB=4'hF for instructions without a register byte.
REQ-020 SHALL assert out_valid when count >= length of head instruction, or immediately with out_adr_err=1 when the head byte is present and dec_pc+length > IMEM_BYTES.
REQ-021 SHALL set out_pc=dec_pc and out_valP=dec_pc+length, 64-bit wrap-around.
REQ-022 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid & out_ready, pop length bytes and set dec_pc=out_valP in that cycle.
REQ-024 SHALL, in the same edge, support simultaneous enqueue and pop with count updated by the net difference.
REQ-025 SHALL implement a two-state FSM: RUN, and HALT entered when icode 0, out_invalid or out_adr_err is accepted.
REQ-026 In HALT: halted=1, no mem_req, out_valid=0.
REQ-027 SHALL leave HALT only via redirect.
REQ-028 SHALL, on redirect_valid, flush the queue (count=0), set fetch_pc=dec_pc=redirect_pc, go to RUN, and discard the response of any request outstanding at that edge.
REQ-029 SHALL issue no new mem_req in the redirect cycle.
REQ-030 SHALL give redirect priority over a simultaneous handshake or mem_rvalid.
REQ-031 SHALL ignore mem_rvalid when no request is outstanding.

Reset
REQ-032 SHALL, while rst_n=0, asynchronously force: fetch_pc=dec_pc=0, count=0, no outstanding request, state RUN.
REQ-033 SHALL, while rst_n=0, asynchronously force all outputs to 0: mem_req, mem_addr, out_valid, out_*, halted.
REQ-034 SHALL discard any response in flight when reset is asserted mid-operation.
REQ-035 SHALL issue the first mem_req to address 0 in the first cycle after rst_n rises.

Verification
REQ-036 SHALL be verified with bytes 60 03 20 03 10 00 at 0, out_ready=1: four outputs with pc/valP 0/2, 2/4, 4/5, 5/6; the last has icode 0, then halted=1.
REQ-037 SHALL be verified with bytes 30 F3 00 00 00 00 00 00 00 0F: icode 3, rA=F, rB=3, valC=0x0F, valP=10 presented only after count >= 10.
REQ-038 SHALL be verified with out_ready=0 for 20 cycles: outputs stable, count saturates, and mem_req stops when free space < FETCH_BYTES.
REQ-039 SHALL be verified with redirect_pc=0x40 while a request is outstanding: the stale mem_rvalid data is dropped, and the next out_pc=0x40.
REQ-040 SHALL be verified with head byte E0: out_invalid=1, valP=pc+1, then HALT; a later redirect resumes fetch.
REQ-041 SHALL be verified with a 10-byte instruction at 1020 when IMEM_BYTES=1024: out_adr_err=1, then halted.
